// File: rtl/sdpram_arbiter_pkg.sv
// Shared types for the simple dual-port RAM arbiter.
// The stage-1 read tag carries the write data/strobes so that the
// SDPRAM_ARBITER_FWD_EN build can merge a colliding write into the read data.
package sdpram_arbiter_pkg;

    localparam int NUM_REQ = 2;

    // Widest DATA_WIDTH the read tag can carry; narrower words use the low bits.
    localparam int TAG_DATA_W = 256;
    localparam int TAG_STRB_W = TAG_DATA_W / 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic                  valid;
        req_id_t               id;
        logic                  fwd;
        logic [TAG_DATA_W-1:0] wdata;
        logic [TAG_STRB_W-1:0] wstrb;
    } rd_tag_t;

endpackage

// File: rtl/sdpram_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins
// a contested cycle and flips to the other one only when that contested
// grant is actually taken (en high).
module rr_arbiter2
    import sdpram_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    req_id_t ptr;
    logic    contested;

    assign contested = &req;

    // Grant: a lone requester always wins, otherwise the pointer decides.
    always_comb begin
        gnt = req;
        if (contested) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // Pointer: move away from the winner after a contested grant is taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (contested && en) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/sdpram_arbiter.sv
// Front end for a simple dual-port RAM: independent round-robin arbitration
// of the write port (A) and read port (B), one registered RAM stage, and
// read data returned two cycles after acceptance to the issuing requester.
// A same-cycle read/write to one address stalls the read by a cycle, unless
// SDPRAM_ARBITER_FWD_EN is defined, in which case both are granted and the
// written bytes are merged into the returned read data.
module sdpram_arbiter
    import sdpram_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_data,
    output logic [STRB_WIDTH-1:0]               ram_wena,
    output logic [ADDR_WIDTH-1:0]               ram_addra,
    output logic [DATA_WIDTH-1:0]               ram_dina,
    output logic                                ram_renb,
    output logic [ADDR_WIDTH-1:0]               ram_addrb,
    input  logic [DATA_WIDTH-1:0]               ram_doutb
);

    logic [NUM_REQ-1:0] wr_req, rd_req;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt_raw, rd_gnt;
    req_id_t            wr_id, rd_id;
    logic               wr_any, rd_any_raw, rd_any;
    logic               collision, stall, fwd_hit;
    rd_tag_t            tag_p1, tag_p2;
    logic               unused_tag_bits;

    // Byte-wise merge of forwarded write data over the RAM read word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic                  fwd,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [STRB_WIDTH-1:0] wstrb,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [DATA_WIDTH-1:0] m;
        m = rdata;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (fwd && wstrb[k]) begin
                m[k*8 +: 8] = wdata[k*8 +: 8];
            end
        end
        return m;
    endfunction

    // Nothing is granted while reset is held.
    assign wr_req = req_valid &  req_we & {NUM_REQ{rst}};
    assign rd_req = req_valid & ~req_we & {NUM_REQ{rst}};

    rr_arbiter2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .en  (1'b1),
        .gnt (wr_gnt)
    );

    // A stalled read must not advance the read pointer.
    rr_arbiter2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .en  (~stall),
        .gnt (rd_gnt_raw)
    );

    assign wr_id      = wr_gnt[1];
    assign rd_id      = rd_gnt_raw[1];
    assign wr_any     = |wr_gnt;
    assign rd_any_raw = |rd_gnt_raw;
    assign collision  = wr_any && rd_any_raw && (req_addr[wr_id] == req_addr[rd_id]);

`ifdef SDPRAM_ARBITER_FWD_EN
    assign stall   = 1'b0;
    assign fwd_hit = collision;
`else
    assign stall   = collision;
    assign fwd_hit = 1'b0;
`endif

    assign rd_gnt    = stall ? '0 : rd_gnt_raw;
    assign rd_any    = |rd_gnt;
    assign req_ready = wr_gnt | rd_gnt;

    // Stage 1: register the granted write and read onto the RAM ports.
    always_ff @(posedge clk) begin
        tag_p1.wdata <= TAG_DATA_W'(req_wdata[wr_id]);
        tag_p1.wstrb <= TAG_STRB_W'(req_wstrb[wr_id]);
        if (!rst) begin
            ram_wena     <= '0;
            ram_addra    <= '0;
            ram_dina     <= '0;
            ram_renb     <= 1'b0;
            ram_addrb    <= '0;
            tag_p1.valid <= 1'b0;
            tag_p1.id    <= 1'b0;
            tag_p1.fwd   <= 1'b0;
        end else begin
            ram_wena     <= wr_any ? req_wstrb[wr_id] : '0;
            ram_renb     <= rd_any;
            tag_p1.valid <= rd_any;
            tag_p1.id    <= rd_id;
            tag_p1.fwd   <= fwd_hit;
            if (wr_any) begin
                ram_addra <= req_addr[wr_id];
                ram_dina  <= req_wdata[wr_id];
            end
            if (rd_any) begin
                ram_addrb <= req_addr[rd_id];
            end
        end
    end

    // Stage 2: track the read whose RAM data arrives this cycle.
    always_ff @(posedge clk) begin
        tag_p2 <= tag_p1;
        if (!rst) begin
            tag_p2.valid <= 1'b0;
        end
    end

    // Steer the (possibly merged) RAM data to the requester that issued the read.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_p2.valid) begin
            rsp_valid[tag_p2.id] = 1'b1;
            rsp_data[tag_p2.id]  = merge_bytes(tag_p2.fwd,
                                               tag_p2.wdata[DATA_WIDTH-1:0],
                                               tag_p2.wstrb[STRB_WIDTH-1:0],
                                               ram_doutb);
        end
    end

    // Tag bits above DATA_WIDTH are carried but never consumed.
    assign unused_tag_bits = ^{tag_p2.wdata, tag_p2.wstrb};

endmodule

// File: doc/sdpram_arbiter.md
# sdpram_arbiter

Two-requester access controller for the simple dual-port RAM. It sits in front of the RAM's write port (A) and read port (B). It arbitrates each port independently with round-robin priority, so one write and one read can issue per cycle. It registers the RAM inputs, detects same-cycle read/write address collisions, and returns read data to the requester that issued the read.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 1024, RAM words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), derived, not overridable.
- STRB_WIDTH, DATA_WIDTH/8, derived byte-enable width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  [2]  request valid, per requester.
- req_ready  output  [2]  request accepted this cycle when valid && ready.
- req_we  input  [2]  1 = write, 0 = read.
- req_addr  input  [2][ADDR_WIDTH]  word address.
- req_wdata  input  [2][DATA_WIDTH]  write data.
- req_wstrb  input  [2][STRB_WIDTH]  byte enables; a write with all zeros is accepted and is a no-op.
- rsp_valid  output  [2]  read data valid, one-cycle pulse; no backpressure.
- rsp_data  output  [2][DATA_WIDTH]  read data.
- ram_wena  output  STRB_WIDTH  RAM port A byte write enables.
- ram_addra  output  ADDR_WIDTH  RAM port A address.
- ram_dina  output  DATA_WIDTH  RAM port A data.
- ram_renb  output  1  RAM port B read enable.
- ram_addrb  output  ADDR_WIDTH  RAM port B address.
- ram_doutb  input  DATA_WIDTH  RAM port B data, registered, valid one cycle after renb is sampled.

## Operation
- **Write arbitration.** Candidates are requesters with valid && we. A round-robin pointer (wptr) selects the winner.
  - With one candidate, that candidate wins.
  - With two, the requester at wptr wins, and wptr then moves to the other requester.
  - wptr only updates on a contested grant.
- **Read arbitration.** Same scheme with an independent pointer (rptr) over valid && !we.
- **Ready.** req_ready[i] is combinational and equals the grant (write or read) for requester i. Non-granted requesters see ready low and must hold their request stable.
- **Stage 1 (registered).**
  - Accepted write: drives ram_wena = wstrb, ram_addra, ram_dina for exactly one cycle.
  - Accepted read: drives ram_renb = 1 and ram_addrb, and records the requester id.
- **Stage 2.** rsp_valid[id] = 1 and rsp_data[id] = ram_doutb. rsp_data for the non-target requester is don't-care.
- **Collision.** A same-cycle granted read and granted write with equal addresses is a collision. Without forwarding, the read grant is withheld (stall); the write proceeds, and the read is granted the next cycle.
- **Idle.** ram_wena = 0 and ram_renb = 0 whenever no request is granted; addr/data hold their last values.
- **Reset.** Both pointers point to requester 0. Pipeline valids and any in-flight response are dropped.

## Timing
- Request accepted in cycle N, RAM port driven in N+1, rsp_valid in N+2. Read latency is fixed at 2 cycles.
- Back-to-back reads are supported at full rate: one read and one write per cycle in aggregate.
- A write accepted in N is visible to any read accepted in N+1 or later.
- Reset values: req_ready 0, rsp_valid 0, ram_wena 0, ram_renb 0, ram_addra/ram_addrb/ram_dina 0, rsp_data 0.
- Reset asserted with a read in stage 1 or 2: rsp_valid is 0 in the cycle after the reset edge, and that response is never delivered.
- Address wrap: none; addresses are ADDR_WIDTH wide and cover the full depth.

## Configuration
- Macro: SDPRAM_ARBITER_FWD_EN.
- **Defined:** a collision does not stall; both the read and the write are granted.
  - Stage 2 merges the data per byte: byte k = write wdata when wstrb[k] = 1, else ram_doutb.
  - Read latency stays 2 cycles.
- **Undefined:** stall behaviour as described under Operation; read latency is 2 cycles from the actual grant.

## Structure
- Package sdpram_arbiter_pkg holds:
  - NUM_REQ = 2.
  - Typedef req_id_t (1 bit).
  - A stage-1 read tag struct {valid, id, fwd, wdata, wstrb}; fwd/wdata/wstrb are only used under SDPRAM_ARBITER_FWD_EN.
- One sub-module, rr_arbiter2: 2-input round-robin arbiter with pointer register. It is instantiated twice, once for writes and once for reads.

## Test plan
- **Single write/read.** Requester 0 writes addr 0x010, data 0xDEADBEEF, wstrb 0xF; then reads 0x010. Required: rsp_valid[0] two cycles after read acceptance with data 0xDEADBEEF.
- **Contested writes.** Both requesters write continuously. Required: grants alternate 0, 1, 0, 1 starting from 0 after reset; ram_wena is never 0 while a write is pending.
- **Concurrent read and write.** Requester 0 writes 0x020 while requester 1 reads 0x030 in the same cycle. Required: both ready high; rsp_valid[1] returns the prior contents of 0x030.
- **Collision.** 0x040 holds 0x11223344. Requester 0 writes 0x040, data 0xAABBCCDD, wstrb 0x3, in the same cycle that requester 1 reads 0x040. Required data 0x1122CCDD in both builds.
  - Without the macro: the read ready is delayed by one cycle.
  - With SDPRAM_ARBITER_FWD_EN: no delay.
- **Reset mid-read.** Read accepted, then rst = 0 in the next cycle. Required: no rsp_valid pulse, all RAM enables 0, and pointers back at requester 0.
- **Random soak.** 1000 random requests checked against a reference memory; zero mismatches and no lost or duplicated responses.
